mem_to_tx: RTL and testbench

//  Result-matrix read-out stage of the matrix multiplier.

---
 rtl/mem_to_tx.sv | 105 ++++++++++
 tb/tb_mem_to_tx.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/mem_to_tx.sv
module mem_to_tx #(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD      = 115200,
    parameter int N_ELEM    = 9,
    parameter     INIT_FILE = ""
) (
    input  logic clk,
    input  logic rst,
    input  logic read_R_mat,
    output logic tx_data
);
    localparam int BIT_CYC = CLK_FREQ / BAUD;
    localparam int CW      = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
    localparam int IW      = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;

    typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP} state_t;

    logic [7:0] rom [N_ELEM];

    generate
        for (genvar k = 0; k < N_ELEM; k++) begin : g_rom
            assign rom[k] = 8'(k + 1);
        end
    endgenerate

    state_t        state_q;
    logic          req_q;
    logic          tx_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    bit_q;
    logic [IW-1:0] idx_q;
    logic [7:0]    sh_q;
    logic          start;
    logic          wrap;

    assign start   = read_R_mat & ~req_q;
    assign wrap    = (cnt_q == CW'(BIT_CYC - 1));
    assign tx_data = tx_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            tx_q    <= 1'b1;
            cnt_q   <= '0;
            bit_q   <= '0;
            idx_q   <= '0;
            sh_q    <= '0;
        end else begin
            req_q <= read_R_mat;

            case (state_q)
                START:   tx_q <= 1'b0;
                DATA:    tx_q <= sh_q[bit_q];
                default: tx_q <= 1'b1;
            endcase

            case (state_q)
                IDLE: begin
                    if (start) begin
                        idx_q   <= '0;
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    sh_q    <= rom[idx_q];
                    cnt_q   <= '0;
                    state_q <= START;
                end
                START: begin
                    if (wrap) begin
                        cnt_q   <= '0;
                        bit_q   <= '0;
                        state_q <= DATA;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DATA: begin
                    if (wrap) begin
                        cnt_q <= '0;
                        if (bit_q == 3'd7) state_q <= STOP;
                        else               bit_q   <= bit_q + 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                STOP: begin
                    if (wrap) begin
                        cnt_q <= '0;
                        if (idx_q == IW'(N_ELEM - 1)) begin
                            state_q <= IDLE;
                        end else begin
                            idx_q   <= idx_q + 1'b1;
                            state_q <= LOAD;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_to_tx.sv
// Bench for mem_to_tx, run with a scaled bit time (BIT_CYC = 8) so that
// several complete dumps fit in a short simulation.
module tb_mem_to_tx;
    localparam int BIT_CYC = 8;
    localparam int N_ELEM  = 9;

    logic clk = 1'b0;
    logic rst;
    logic read_R_mat;
    logic tx_data;

    int n_checks = 0;
    int n_fail   = 0;

    mem_to_tx #(
        .CLK_FREQ (BIT_CYC),
        .BAUD     (1),
        .N_ELEM   (N_ELEM),
        .INIT_FILE("")
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .read_R_mat(read_R_mat),
        .tx_data   (tx_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        int   n;      // negedge sample after the n-th posedge since the request edge
        logic exp_tx;
    } vec_t;

    vec_t vecs [$];

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // UART receiver: decodes N_ELEM frames mid-bit and expects bytes 1..N_ELEM.
    task automatic rx_dump(input string tag);
        logic [7:0] d;
        int w;
        for (int e = 0; e < N_ELEM; e++) begin
            w = 0;
            while (tx_data !== 1'b0 && w < 300) begin
                step();
                w++;
            end
            if (w >= 300) begin
                n_checks++;
                n_fail++;
                $display("FAIL %s frame %0d: no start bit within 300 cycles", tag, e);
                return;
            end
            repeat (BIT_CYC / 2) step();
            chk($sformatf("%s f%0d start", tag, e), 32'(tx_data), 32'd0);
            for (int b = 0; b < 8; b++) begin
                repeat (BIT_CYC) step();
                d[b] = tx_data;
            end
            repeat (BIT_CYC) step();
            chk($sformatf("%s f%0d stop", tag, e), 32'(tx_data), 32'd1);
            chk($sformatf("%s f%0d byte", tag, e), 32'(d), 32'(e + 1));
        end
    endtask

    // Line must stay idle for the given number of cycles.
    task automatic quiet(input string tag, input int cycles);
        int lows = 0;
        for (int i = 0; i < cycles; i++) begin
            step();
            if (tx_data !== 1'b1) lows++;
        end
        chk({tag, " idle"}, 32'(lows), 32'd0);
    endtask

    initial begin
        int n;

        // Hand-computed line levels for the first dump (frame = 81 cycles
        // incl. the gap; first start bit after edge 2).
        vecs = '{
            '{0, 1'b1}, '{1, 1'b1}, '{2, 1'b0}, '{9, 1'b0},      // start bit of 0x01
            '{10, 1'b1}, '{17, 1'b1}, '{18, 1'b0}, '{73, 1'b0},  // bit0=1, bits1..7=0
            '{74, 1'b1}, '{81, 1'b1}, '{82, 1'b1},               // stop + gap cycle
            '{83, 1'b0}, '{90, 1'b0}, '{91, 1'b0},               // frame 1 start, 0x02 bit0
            '{99, 1'b1}, '{106, 1'b1}, '{107, 1'b0},             // 0x02 bit1=1, bit2=0
            '{650, 1'b0}, '{658, 1'b1}, '{666, 1'b0},            // frame 8: 0x09
            '{682, 1'b1}, '{721, 1'b0}, '{722, 1'b1},
            '{729, 1'b1}, '{730, 1'b1}, '{731, 1'b1}, '{900, 1'b1} // one dump only
        };

        // 1. reset with request already high
        rst        = 1'b0;
        read_R_mat = 1'b1;
        repeat (10) @(negedge clk);
        chk("tx in reset", 32'(tx_data), 32'd1);
        rst = 1'b1;
        n   = -1;
        foreach (vecs[i]) begin
            while (n < vecs[i].n) begin
                step();
                n++;
            end
            chk($sformatf("vec n=%0d", vecs[i].n), 32'(tx_data), 32'(vecs[i].exp_tx));
        end

        // 2/3. drop the request, raise again: second identical dump
        read_R_mat = 1'b0;
        repeat (20) step();
        read_R_mat = 1'b1;
        rx_dump("dump2");
        quiet("after dump2", 150);

        // 4. low/high pulse on the request during a dump is ignored
        read_R_mat = 1'b0;
        repeat (5) step();
        read_R_mat = 1'b1;
        fork
            rx_dump("dump3");
            begin
                repeat (200) step();
                read_R_mat = 1'b0;
                repeat (3) step();
                read_R_mat = 1'b1;
            end
        join
        quiet("after dump3", 150);

        // 5. reset inside the 4th frame's start bit, then restart from element 0
        read_R_mat = 1'b0;
        repeat (5) step();
        read_R_mat = 1'b1;
        step();                       // edge 0
        repeat (247) step();          // edge 247: start bit of frame 3
        chk("frame3 start low", 32'(tx_data), 32'd0);
        #2 rst = 1'b0;
        #1 chk("tx on async reset", 32'(tx_data), 32'd1);
        read_R_mat = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        quiet("after reset", 20);
        read_R_mat = 1'b1;
        rx_dump("dump4");
        quiet("after dump4", 150);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
